// File: rtl/exe_mem_pipe_stage.sv
// -----------------------------------------------------------------------------
// exe_mem_pipe_stage
//
// EXE-to-MEM pipeline register with a valid/ready handshake and a two-entry
// skid buffer. It lets the memory stage stall without a combinational ready
// path back into execute. It also counts the cycles in which a beat is held
// because downstream is not ready.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   flush            squash held and incoming beats this cycle
//   in_valid/ready   upstream handshake (in_ready comes straight from a flop)
//   ctrlIn .. writeDataIn    incoming beat fields
//   out_valid/ready  downstream handshake for the main entry
//   ctrlOut .. writeDataOut  main entry fields (ctrlOut is gated by out_valid)
//   stall_cnt        saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module exe_mem_pipe_stage #(
    parameter int CTRL_W      = 3,
    parameter int REG_W       = 5,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      ctrlIn,
    input  logic [REG_W-1:0]       destRegIn,
    input  logic [REG_W-1:0]       RdIn,
    input  logic [DATA_W-1:0]      ALUResIn,
    input  logic [DATA_W-1:0]      writeDataIn,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      ctrlOut,
    output logic [REG_W-1:0]       destRegOut,
    output logic [REG_W-1:0]       RdOut,
    output logic [DATA_W-1:0]      ALUResOut,
    output logic [DATA_W-1:0]      writeDataOut,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // One beat packed as {ctrl, destReg, Rd, ALURes, writeData}, ctrl at the top.
    localparam int ENTRY_W = CTRL_W + 2*REG_W + 2*DATA_W;
    localparam int WD_LSB  = 0;
    localparam int ALU_LSB = WD_LSB + DATA_W;
    localparam int RD_LSB  = ALU_LSB + DATA_W;
    localparam int DST_LSB = RD_LSB + REG_W;
    localparam int CTL_LSB = DST_LSB + REG_W;

    // State encoding is {skid_valid, main_valid}, so each bit is a valid flag.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [ENTRY_W-1:0]     main_q, main_d;
    logic [ENTRY_W-1:0]     skid_q, skid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [ENTRY_W-1:0]     in_entry;
    logic                   main_valid;
    logic                   skid_valid;

    assign in_entry   = {ctrlIn, destRegIn, RdIn, ALUResIn, writeDataIn};
    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];

    // in_ready is a flop output: no path from out_ready to in_ready.
    assign in_ready = ~skid_valid;

    // ------------------------------------------------------------------
    // Next-state / datapath selection
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            S_EMPTY: begin
                if (in_valid) begin
                    state_d = S_ONE;
                    main_d  = in_entry;
                end
            end
            S_ONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        main_d = in_entry;          // pass-through at full rate
                    end else begin
                        state_d = S_EMPTY;
                    end
                end else if (in_valid) begin
                    state_d = S_TWO;                // park the new beat behind main
                    skid_d  = in_entry;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only draining is possible.
                if (out_ready) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        // Flush overrides all movement; data fields just keep their old value.
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // Saturating back-pressure counter; flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid    = main_valid;
    assign destRegOut   = main_q[DST_LSB +: REG_W];
    assign RdOut        = main_q[RD_LSB  +: REG_W];
    assign ALUResOut    = main_q[ALU_LSB +: DATA_W];
    assign writeDataOut = main_q[WD_LSB  +: DATA_W];
    assign stall_cnt    = stall_cnt_q;

    // A bubble never leaks stale control bits downstream.
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
        assign ctrlOut[gi] = main_q[CTL_LSB + gi] & main_valid;
    end

endmodule
